// File: rtl/l1_pkg.sv
// Shared types and geometry for the direct-mapped, write-through L1 controller.
// Geometry is fixed here so the packed line struct has concrete widths.
package l1_pkg;

    localparam int WORD_SIZE     = 32;
    localparam int L1_INDEX_BITS = 3;
    localparam int L1_TAG_BITS   = WORD_SIZE - L1_INDEX_BITS;
    localparam int L1_LINES      = 2 ** L1_INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        L2_REQ,
        RESP
    } l1_state_e;

    typedef struct packed {
        logic                   valid;
        logic [L1_TAG_BITS-1:0] tag;
        logic [WORD_SIZE-1:0]   data;
    } l1_line_t;

    function automatic logic [L1_INDEX_BITS-1:0] addr_index(input logic [WORD_SIZE-1:0] addr);
        return addr[L1_INDEX_BITS-1:0];
    endfunction

    function automatic logic [L1_TAG_BITS-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr);
        return addr[WORD_SIZE-1:L1_INDEX_BITS];
    endfunction

endpackage

// File: rtl/l1_ctrl_if.sv
// CPU request/response handshake and L2 request bus seen by the L1 controller.
// The controller takes the slave side; the CPU/L2 environment takes the master side.
interface l1_ctrl_if;
    import l1_pkg::*;

    logic                 cpu_req_valid;
    logic                 cpu_req_ready;
    logic                 cpu_wr;
    logic [WORD_SIZE-1:0] cpu_addr;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic                 cpu_resp_valid;
    logic [WORD_SIZE-1:0] cpu_rdata;
    logic                 cpu_resp_hit;
    logic                 cpu_resp_err;
    logic                 l2_wr_en;
    logic [WORD_SIZE-1:0] l2_addr;
    logic [WORD_SIZE-1:0] l2_data;
    logic [WORD_SIZE-1:0] l2_data_out;
    logic                 l2_hit_or_miss;

    modport slave (
        input  cpu_req_valid, cpu_wr, cpu_addr, cpu_wdata, l2_data_out, l2_hit_or_miss,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_resp_hit, cpu_resp_err,
               l2_wr_en, l2_addr, l2_data
    );

    modport master (
        output cpu_req_valid, cpu_wr, cpu_addr, cpu_wdata, l2_data_out, l2_hit_or_miss,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_resp_hit, cpu_resp_err,
               l2_wr_en, l2_addr, l2_data
    );

endinterface

// File: rtl/l1_tag_array.sv
// One-word-per-line L1 storage: asynchronous read, single synchronous write port.
// Reset clears every line, which invalidates the whole cache.
module l1_tag_array
    import l1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [L1_INDEX_BITS-1:0] rd_index,
    output l1_line_t                 rd_line,
    input  logic                     wr_en,
    input  logic [L1_INDEX_BITS-1:0] wr_index,
    input  l1_line_t                 wr_line
);

    l1_line_t lines [L1_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L1_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (wr_en) begin
            lines[wr_index] <= wr_line;
        end
    end

    assign rd_line = lines[rd_index];

endmodule

// File: rtl/l1_ctrl.sv
// Direct-mapped write-through L1 controller: read hits served locally, misses and writes go to L2.
// Optional hit/miss counters are built only when L1_STATS_EN is defined (ports tie to 0 otherwise).
module l1_ctrl
    import l1_pkg::*;
#(
    parameter int L2_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    l1_ctrl_if.slave    bus,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
);

    localparam logic [3:0] LAST_CNT = 4'(L2_LATENCY - 1);

    l1_state_e                state;
    logic [3:0]               lat_cnt;
    logic                     req_wr;
    logic [WORD_SIZE-1:0]     req_addr;
    logic [WORD_SIZE-1:0]     req_wdata;
    logic [L1_INDEX_BITS-1:0] req_index;
    logic [L1_TAG_BITS-1:0]   req_tag;
    l1_line_t                 cur_line;
    l1_line_t                 fill_line;
    logic                     fill_en;
    logic                     l2_last;

    assign req_index         = addr_index(req_addr);
    assign req_tag           = addr_tag(req_addr);
    assign l2_last           = (state == L2_REQ) && (lat_cnt == LAST_CNT);
    assign bus.cpu_req_ready = (state == IDLE) && !rst;

    l1_tag_array u_tags (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_line  (cur_line),
        .wr_en    (fill_en),
        .wr_index (req_index),
        .wr_line  (fill_line)
    );

    // L1 update at the end of an L2 access: fill on read hit, allocate on accepted
    // write, drop a matching line when the write is rejected.
    always_comb begin
        fill_en         = 1'b0;
        fill_line.valid = 1'b1;
        fill_line.tag   = req_tag;
        fill_line.data  = bus.l2_data_out;
        if (l2_last) begin
            if (!req_wr) begin
                fill_en = bus.l2_hit_or_miss;
            end else if (bus.l2_hit_or_miss) begin
                fill_en        = 1'b1;
                fill_line.data = req_wdata;
            end else begin
                fill_en         = (cur_line.tag == req_tag);
                fill_line       = cur_line;
                fill_line.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            lat_cnt            <= '0;
            req_wr             <= 1'b0;
            req_addr           <= '0;
            req_wdata          <= '0;
            bus.cpu_resp_valid <= 1'b0;
            bus.cpu_rdata      <= '0;
            bus.cpu_resp_hit   <= 1'b0;
            bus.cpu_resp_err   <= 1'b0;
            bus.l2_wr_en       <= 1'b0;
            bus.l2_addr        <= '0;
            bus.l2_data        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        req_wr    <= bus.cpu_wr;
                        req_addr  <= bus.cpu_addr;
                        req_wdata <= bus.cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!req_wr && cur_line.valid && (cur_line.tag == req_tag)) begin
                        bus.cpu_resp_valid <= 1'b1;
                        bus.cpu_rdata      <= cur_line.data;
                        bus.cpu_resp_hit   <= 1'b1;
                        bus.cpu_resp_err   <= 1'b0;
                        state              <= RESP;
                    end else begin
                        lat_cnt      <= '0;
                        bus.l2_addr  <= req_addr;
                        bus.l2_data  <= req_wdata;
                        bus.l2_wr_en <= req_wr;
                        state        <= L2_REQ;
                    end
                end
                // L2 request is held stable; the edge ending the last cycle samples the reply.
                L2_REQ: begin
                    if (lat_cnt == LAST_CNT) begin
                        bus.l2_wr_en       <= 1'b0;
                        bus.cpu_resp_valid <= 1'b1;
                        bus.cpu_resp_hit   <= 1'b0;
                        bus.cpu_resp_err   <= !bus.l2_hit_or_miss;
                        bus.cpu_rdata      <= (!req_wr && bus.l2_hit_or_miss) ? bus.l2_data_out : '0;
                        state              <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    bus.cpu_resp_valid <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L1_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // Saturating counters sampled during the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESP) begin
            if (bus.cpu_resp_hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (!req_wr && !bus.cpu_resp_hit && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign stat_hits   = hit_cnt;
    assign stat_misses = miss_cnt;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_l1_ctrl.sv
// Scoreboard bench for l1_ctrl: a cache-contents model predicts each response at accept time,
// and a monitor checks responses, latency and the L2 write protocol as they appear.
module tb_l1_ctrl;

    localparam int L2_LAT = 2;
    localparam int LINES  = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        logic        err;
        int          lat;
        time         t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;

    l1_ctrl_if dut_if ();

    l1_ctrl #(.L2_LATENCY(L2_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (dut_if),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic        cur_wr    = 1'b0;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_wdata = '0;
    logic [31:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    bit          m_valid [LINES];
    int          model_hits   = 0;
    int          model_misses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        model_hits   = 0;
        model_misses = 0;
    endtask

    // Cache behaviour stated in terms of whole addresses: a line holds one address and its word.
    function automatic exp_t predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic l2ok, input logic [31:0] l2data);
        exp_t e;
        int   idx = int'(addr % LINES);
        e.rdata = '0;
        e.hit   = 1'b0;
        e.err   = !l2ok;
        e.lat   = 2 + L2_LAT;
        e.t0    = 0;
        if (!wr) begin
            if (m_valid[idx] && m_addr[idx] == addr) begin
                e.hit   = 1'b1;
                e.err   = 1'b0;
                e.rdata = m_data[idx];
                e.lat   = 2;
                model_hits++;
            end else begin
                model_misses++;
                if (l2ok) begin
                    e.rdata     = l2data;
                    m_valid[idx] = 1'b1;
                    m_addr[idx]  = addr;
                    m_data[idx]  = l2data;
                end
            end
        end else if (l2ok) begin
            m_valid[idx] = 1'b1;
            m_addr[idx]  = addr;
            m_data[idx]  = wdata;
        end else if (m_addr[idx] == addr) begin
            m_valid[idx] = 1'b0;
        end
        return e;
    endfunction

    // Waits for ready, presents one request with its L2 reply, and queues the prediction.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic l2ok, input logic [31:0] l2data);
        int   n = 0;
        exp_t e;
        while (!dut_if.cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dut_if.cpu_req_ready) begin
            checkOutput("ready_timeout", 32'(dut_if.cpu_req_ready), 32'd1);
            return;
        end
        dut_if.cpu_wr         = wr;
        dut_if.cpu_addr       = addr;
        dut_if.cpu_wdata      = wdata;
        dut_if.l2_hit_or_miss = l2ok;
        dut_if.l2_data_out    = l2data;
        dut_if.cpu_req_valid  = 1'b1;
        @(posedge clk);
        e         = predict(wr, addr, wdata, l2ok, l2data);
        e.t0      = $time;
        cur_wr    = wr;
        cur_addr  = addr;
        cur_wdata = wdata;
        exp_q.push_back(e);
        @(negedge clk);
        dut_if.cpu_req_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"},  32'(dut_if.cpu_req_ready),  32'd0);
        checkOutput({tag, "_rvalid"}, 32'(dut_if.cpu_resp_valid), 32'd0);
        checkOutput({tag, "_rdata"},  dut_if.cpu_rdata,           32'd0);
        checkOutput({tag, "_hit"},    32'(dut_if.cpu_resp_hit),   32'd0);
        checkOutput({tag, "_err"},    32'(dut_if.cpu_resp_err),   32'd0);
        checkOutput({tag, "_l2wr"},   32'(dut_if.l2_wr_en),       32'd0);
        checkOutput({tag, "_l2addr"}, dut_if.l2_addr,             32'd0);
        checkOutput({tag, "_l2data"}, dut_if.l2_data,             32'd0);
        checkOutput({tag, "_shits"},  32'(stat_hits),             32'd0);
        checkOutput({tag, "_smiss"},  32'(stat_misses),           32'd0);
    endtask

    // Monitor: pops a prediction for every response and polices the L2 write window.
    initial begin : monitor
        int   run = 0;
        int   lat;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (dut_if.l2_wr_en) begin
                    run++;
                    checkOutput("l2_wr_on_write", 32'(cur_wr), 32'd1);
                    checkOutput("l2_addr_stable", dut_if.l2_addr, cur_addr);
                    checkOutput("l2_data_stable", dut_if.l2_data, cur_wdata);
                end else if (run != 0) begin
                    checkOutput("l2_wr_cycles", 32'(run), 32'(L2_LAT));
                    run = 0;
                end
                if (dut_if.cpu_resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        lat = int'(($time - e.t0 + 5) / 10);
                        checkOutput("resp_rdata",   dut_if.cpu_rdata,          e.rdata);
                        checkOutput("resp_hit",     32'(dut_if.cpu_resp_hit),  32'(e.hit));
                        checkOutput("resp_err",     32'(dut_if.cpu_resp_err),  32'(e.err));
                        checkOutput("resp_latency", 32'(lat),                  32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int          n;
        logic [31:0] exp_hits;
        logic [31:0] exp_misses;

        dut_if.cpu_req_valid  = 1'b0;
        dut_if.cpu_wr         = 1'b0;
        dut_if.cpu_addr       = '0;
        dut_if.cpu_wdata      = '0;
        dut_if.l2_data_out    = '0;
        dut_if.l2_hit_or_miss = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'h0BADF00D);
        applyStimulus(1'b0, 32'h41, 32'h0, 1'b0, 32'h11111111);
        applyStimulus(1'b0, 32'h41, 32'h0, 1'b0, 32'h22222222);
        applyStimulus(1'b1, 32'h42, 32'h12345678, 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h42, 32'h0, 1'b1, 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'h08, 32'h0, 1'b1, 32'hAAAA0008);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hBBBB0010);
        applyStimulus(1'b0, 32'h08, 32'h0, 1'b1, 32'hAAAA0008);
        applyStimulus(1'b0, 32'h08, 32'h0, 1'b1, 32'hCCCCCCCC);

        // Abandon a write mid-L2 access with an asynchronous reset.
        applyStimulus(1'b1, 32'h44, 32'hCAFEF00D, 1'b1, 32'h0);
        n = 0;
        while (!dut_if.l2_wr_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("l2_wr_before_reset", 32'(dut_if.l2_wr_en), 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        modelReset();
        #1;
        checkResetOutputs("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'h40404040);
        applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'h0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 23)), $urandom(),
                          1'($urandom_range(0, 3) != 0), $urandom());
        end

        n = 0;
        while ((exp_q.size() != 0 || !dut_if.cpu_req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

`ifdef L1_STATS_EN
        exp_hits   = 32'(model_hits);
        exp_misses = 32'(model_misses);
`else
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
`endif
        checkOutput("stat_hits",   32'(stat_hits),   exp_hits);
        checkOutput("stat_misses", 32'(stat_misses), exp_misses);

        $display("[TB] model saw %0d read hits and %0d read misses", model_hits, model_misses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_ctrl.md
Name: l1_ctrl

Overview:
- Initiator for the L2 interface: a direct-mapped, write-through L1 controller.
- Accepts CPU word requests over a valid/ready handshake and serves read hits locally from L1.
- Forwards read misses and all writes to L2 using the L2 two-cycle request protocol.
- Fills L1 from L2 read data; sits between the CPU port and the L2 block.

Parameters:
- WORD_SIZE, 32, data and address width in bits.
- L1_INDEX_BITS, 3, L1 index width; L1 holds 2**L1_INDEX_BITS lines of one word each.
- L2_LATENCY, 2, cycles each L2 request is held stable before response sampling; legal values 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  WORD_SIZE  word address.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_rdata  out  WORD_SIZE  read data; 0 for writes and errors.
- cpu_resp_hit  out  1  request was served from L1.
- cpu_resp_err  out  1  L2 reported miss on a read, or full set on a write.
- l2_wr_en  out  1  L2 write enable.
- l2_addr  out  WORD_SIZE  L2 address.
- l2_data  out  WORD_SIZE  L2 write data.
- l2_data_out  in  WORD_SIZE  L2 returned data.
- l2_hit_or_miss  in  1  L2 hit (read) or write accepted.
- stat_hits  out  16  L1 hit count (optional feature).
- stat_misses  out  16  L1 miss count (optional feature).

Behaviour:
- Reset state and values:
  - Reset is asynchronous and active-high; clock is clk, reset is rst.
  - On reset: state IDLE, all L1 valid bits 0.
  - Outputs on reset: cpu_resp_valid=0, cpu_rdata=0, cpu_resp_hit=0, cpu_resp_err=0, l2_wr_en=0, l2_addr=0, l2_data=0, stat counters=0.
  - cpu_req_ready is 0 while rst is high.
- Address split: index = cpu_addr[L1_INDEX_BITS-1:0]; tag = cpu_addr[WORD_SIZE-1:L1_INDEX_BITS].
- Handshake and request capture:
  - cpu_req_ready = (state==IDLE) && !rst.
  - A request is accepted on a rising edge with valid && ready; addr, wdata and wr are registered at that edge.
  - valid while not ready is ignored; the CPU must hold its request.
- FSM states: IDLE, LOOKUP, L2_REQ, RESP.
- IDLE -> LOOKUP on accept.
- LOOKUP (1 cycle):
  - Read with valid && tag match -> RESP with rdata = line data, hit=1.
  - Any other case -> L2_REQ; counter cleared to 0.
- L2_REQ:
  - l2_addr = captured addr, l2_data = captured wdata, l2_wr_en = captured wr.
  - All three are held constant for exactly L2_LATENCY cycles.
  - On the edge ending the last cycle, sample l2_hit_or_miss and l2_data_out, then go to RESP.
  - On exit l2_wr_en returns to 0; l2_addr and l2_data hold their last value.
- Read resolution:
  - L2 hit: L1 line filled {valid=1, tag, l2_data_out}; rdata = l2_data_out; err=0.
  - L2 miss: no fill; rdata=0; err=1.
- Write resolution (write-allocate on success):
  - L2 accepted: L1 line = {1, tag, wdata}; err=0.
  - L2 rejected: err=1; if the L1 line tag matches it is invalidated, otherwise untouched.
  - Writes always report hit=0.
- RESP (1 cycle): cpu_resp_valid=1 with its data and flags -> IDLE.
- Latency:
  - Read hit: response 2 cycles after accept.
  - Miss or write: response 2+L2_LATENCY cycles after accept.
  - Back-to-back requests: a new accept is possible on the edge after the RESP cycle.
- Boundaries:
  - A fill overwrites any valid line with a different tag (conflict eviction).
  - The same index hit immediately after a fill is served from L1.
  - Reset mid-L2_REQ: transaction abandoned, no response, l2_wr_en drops immediately, L1 contents invalidated.

Optional Feature:
- Macro: L1_STATS_EN.
- With L1_STATS_EN defined:
  - stat_hits increments on each RESP with hit=1.
  - stat_misses increments on each read RESP with hit=0.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Without L1_STATS_EN: both ports present and tied to 0; no counter flops.

Decomposition:
- Package l1_pkg:
  - State enum l1_state_e {IDLE, LOOKUP, L2_REQ, RESP}.
  - Line struct {valid, tag, data}.
  - Localparams for the tag width and line count.
- Sub-module l1_tag_array:
  - Line storage with async read and single write port.
  - Invalidate-all on rst.

Test Plan:
- Read 0x40 after reset, L2 returns hit with 0xDEADBEEF:
  - Response at 2+2 cycles: rdata=0xDEADBEEF, hit=0, err=0.
  - Repeat read of 0x40: response 2 cycles after accept, hit=1.
- Read 0x41, L2 returns miss -> rdata=0, err=1, no fill; repeat read goes to L2 again.
- Write 0x42 = 0x12345678, L2 accepts:
  - l2_wr_en=1 for exactly 2 cycles with stable address and data.
  - Subsequent read of 0x42 hits with 0x12345678.
- Conflict:
  - Fill 0x08 (index 0), then read 0x10 (index 0, new tag) -> L2 access, line replaced.
  - Read of 0x08 then misses.
- Assert rst during L2_REQ:
  - l2_wr_en=0 immediately, no cpu_resp_valid.
  - After release, read 0x40 misses L1.
- L1_STATS_EN, 3 hits and 2 read misses -> stat_hits=3, stat_misses=2.
